// File: rtl/capture_pkg.sv
// Shared types and helpers for the capture sequencer.
//   state_e  : sequencer states (idle, collect, drain, flush)
//   SAMPLE_W : generator / USB word width
//   cnt_w()  : bit width needed to hold a count in the range 0..n
package capture_pkg;

  localparam int unsigned SAMPLE_W = 16;

  typedef enum logic [1:0] {
    StIdle,
    StCollect,
    StDrain,
    StFlush
  } state_e;

  function automatic int unsigned cnt_w(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/capture_fifo.sv
// Single-clock synchronous FIFO with registered read data.
//   inclk  : clock
//   nReset : asynchronous active-low reset (empties the FIFO, clears dout)
//   push   : write din this cycle (never issued when full)
//   pop    : read one word; it appears on dout after the clock edge (never issued when empty)
//   din    : write data
//   dout   : registered read data, holds until the next pop
//   count  : words currently stored, 0..Depth
module capture_fifo
  import capture_pkg::*;
#(
  parameter int unsigned Depth = 16
) (
  input  logic                       inclk,
  input  logic                       nReset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [SAMPLE_W-1:0]        din,
  output logic [SAMPLE_W-1:0]        dout,
  output logic [cnt_w(Depth)-1:0]    count
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = cnt_w(Depth);

  logic [SAMPLE_W-1:0] mem_q [Depth];
  logic [PtrW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]     count_q;
  logic [SAMPLE_W-1:0] dout_q;

  // Depth is a power of two, so pointers wrap naturally.
  always_ff @(posedge inclk or negedge nReset) begin
    if (!nReset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      dout_q   <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
        dout_q   <= mem_q[rd_ptr_q];
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge inclk) begin
    if (push) mem_q[wr_ptr_q] <= din;
  end

  assign dout  = dout_q;
  assign count = count_q;

endmodule

// File: rtl/capture_sequencer.sv
// Capture session sequencer: gates the sample generator, paces reads into an internal FIFO
// and hands words to the USB write side in fixed-length bursts, flushing the tail on stop.
//   inclk, nReset        : clock, asynchronous active-low reset
//   collectEnable        : host capture request (level)
//   testModeIn/testMode  : host test-mode select / value latched at session start
//   genAvailable/genData : generator has a sample / sample word
//   collectData/readData : generator enable / one-cycle read strobe
//   usbReady             : USB side can take a full burst
//   usbWrite/usbData     : USB word valid / word
//   burstEnd             : last word of a burst
//   overflow             : sticky, a sample was refused during capture
//   busy                 : sequencer not idle
// Build option CAPTURE_PAD_EN: pad the short final burst with zero words to BURST_LEN.
module capture_sequencer
  import capture_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH  = 16,
  parameter int unsigned BURST_LEN   = 8,
  parameter int unsigned GEN_LATENCY = 1
) (
  input  logic                inclk,
  input  logic                nReset,
  input  logic                collectEnable,
  input  logic                testModeIn,
  input  logic                genAvailable,
  input  logic [SAMPLE_W-1:0] genData,
  output logic                collectData,
  output logic                readData,
  output logic                testMode,
  input  logic                usbReady,
  output logic                usbWrite,
  output logic [SAMPLE_W-1:0] usbData,
  output logic                burstEnd,
  output logic                overflow,
  output logic                busy
);

  localparam int unsigned CntW = cnt_w(FIFO_DEPTH);
  localparam int unsigned BlW  = cnt_w(BURST_LEN);
  localparam int unsigned LatW = cnt_w(GEN_LATENCY);

  state_e                 state_q, state_d;
  logic                   test_mode_q, test_mode_d;
  logic                   overflow_q, overflow_d;
  logic [GEN_LATENCY-1:0] vld_q, vld_d;
  logic [LatW-1:0]        in_flight;
  logic                   space_ok;

  logic                   burst_q, burst_d;
  logic [BlW-1:0]         words_left_q, words_left_d;  // emits still owed after this one
  logic [BlW-1:0]         data_left_q, data_left_d;    // pops still owed after this one
  logic [BlW-1:0]         avail;
  logic                   start_ok;
  logic                   usb_write_q, usb_write_d;
  logic                   burst_end_q, burst_end_d;
  logic                   pad_q, pad_d;

  logic                   fifo_pop;
  logic [CntW-1:0]        fifo_count;
  logic [SAMPLE_W-1:0]    fifo_dout;

  capture_fifo #(
    .Depth(FIFO_DEPTH)
  ) u_fifo (
    .inclk (inclk),
    .nReset(nReset),
    .push  (vld_q[GEN_LATENCY-1]),
    .pop   (fifo_pop),
    .din   (genData),
    .dout  (fifo_dout),
    .count (fifo_count)
  );

  // Read strobes travel alongside the generator latency; the tail pushes genData.
  if (GEN_LATENCY == 1) begin : g_lat1
    assign vld_d = readData;
  end else begin : g_latn
    assign vld_d = {vld_q[GEN_LATENCY-2:0], readData};
  end

  always_comb begin
    in_flight = '0;
    for (int unsigned i = 0; i < GEN_LATENCY; i++) begin
      in_flight = in_flight + LatW'(vld_q[i]);
    end
  end

  // Pops this cycle are not credited, keeping the check conservative.
  assign space_ok = (32'(fifo_count) + 32'(in_flight)) < FIFO_DEPTH;

  always_comb begin
    state_d     = state_q;
    test_mode_d = test_mode_q;
    overflow_d  = overflow_q;
    collectData = 1'b0;
    readData    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (collectEnable) begin
          test_mode_d = testModeIn;
          overflow_d  = 1'b0;
          state_d     = StCollect;
        end
      end
      StCollect: begin
        collectData = 1'b1;
        if (!collectEnable) begin
          state_d = StDrain;
        end else if (genAvailable) begin
          if (space_ok) readData = 1'b1;
          else          overflow_d = 1'b1;
        end
      end
      StDrain: begin
        if (in_flight == '0) state_d = StFlush;
      end
      StFlush: begin
        if (fifo_count == '0 && !burst_q) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Burst engine: the start cycle issues the first pop, so usbWrite (registered) runs for
  // exactly the burst length on consecutive cycles.
  assign avail = (32'(fifo_count) >= BURST_LEN) ? BlW'(BURST_LEN) : BlW'(fifo_count);
  assign start_ok = !burst_q && usbReady && (state_q != StIdle) &&
                    ((32'(fifo_count) >= BURST_LEN) ||
                     (state_q == StFlush && fifo_count != '0));

  always_comb begin
    burst_d      = burst_q;
    words_left_d = words_left_q;
    data_left_d  = data_left_q;
    usb_write_d  = 1'b0;
    burst_end_d  = 1'b0;
    pad_d        = 1'b0;
    fifo_pop     = 1'b0;
    if (burst_q) begin
      usb_write_d  = 1'b1;
      fifo_pop     = (data_left_q != '0);
      pad_d        = !fifo_pop;
      burst_end_d  = (words_left_q == BlW'(1));
      words_left_d = words_left_q - BlW'(1);
      if (fifo_pop) data_left_d = data_left_q - BlW'(1);
      burst_d      = !burst_end_d;
    end else if (start_ok) begin
      usb_write_d  = 1'b1;
      fifo_pop     = 1'b1;
`ifdef CAPTURE_PAD_EN
      words_left_d = BlW'(BURST_LEN - 1);
`else
      words_left_d = avail - BlW'(1);
`endif
      data_left_d  = avail - BlW'(1);
      burst_end_d  = (words_left_d == '0);
      burst_d      = !burst_end_d;
    end
  end

  always_ff @(posedge inclk or negedge nReset) begin
    if (!nReset) begin
      state_q      <= StIdle;
      test_mode_q  <= 1'b0;
      overflow_q   <= 1'b0;
      vld_q        <= '0;
      burst_q      <= 1'b0;
      words_left_q <= '0;
      data_left_q  <= '0;
      usb_write_q  <= 1'b0;
      burst_end_q  <= 1'b0;
      pad_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      test_mode_q  <= test_mode_d;
      overflow_q   <= overflow_d;
      vld_q        <= vld_d;
      burst_q      <= burst_d;
      words_left_q <= words_left_d;
      data_left_q  <= data_left_d;
      usb_write_q  <= usb_write_d;
      burst_end_q  <= burst_end_d;
      pad_q        <= pad_d;
    end
  end

  assign usbWrite = usb_write_q;
  assign usbData  = pad_q ? '0 : fifo_dout;
  assign burstEnd = burst_end_q;
  assign overflow = overflow_q;
  assign testMode = test_mode_q;
  assign busy     = (state_q != StIdle);

endmodule

// File: tb/tb_capture_sequencer.sv
// Directed bench for capture_sequencer (GEN_LATENCY = 3). The generator model returns an
// incrementing word Lat cycles after each readData; a monitor logs every USB word.
module tb_capture_sequencer;
  import capture_pkg::*;

  localparam int unsigned Depth    = 16;
  localparam int unsigned BurstLen = 8;
  localparam int unsigned Lat      = 3;
`ifdef CAPTURE_PAD_EN
  localparam bit PadEn = 1'b1;
`else
  localparam bit PadEn = 1'b0;
`endif

  logic        inclk         = 1'b0;
  logic        nReset        = 1'b1;
  logic        collectEnable = 1'b0;
  logic        testModeIn    = 1'b0;
  logic        genAvailable  = 1'b0;
  logic        usbReady      = 1'b0;
  logic [15:0] genData;
  logic        collectData, readData, testMode, usbWrite, burstEnd, overflow, busy;
  logic [15:0] usbData;

  int n_chk  = 0;
  int n_fail = 0;

  logic [Lat-1:0] rd_pipe;
  logic [15:0]    gen_word = 16'h0;
  logic [15:0]    log_data [256];
  logic           log_end  [256];
  int             log_n = 0;

  capture_sequencer #(
    .FIFO_DEPTH (Depth),
    .BURST_LEN  (BurstLen),
    .GEN_LATENCY(Lat)
  ) dut (
    .inclk        (inclk),
    .nReset       (nReset),
    .collectEnable(collectEnable),
    .testModeIn   (testModeIn),
    .genAvailable (genAvailable),
    .genData      (genData),
    .collectData  (collectData),
    .readData     (readData),
    .testMode     (testMode),
    .usbReady     (usbReady),
    .usbWrite     (usbWrite),
    .usbData      (usbData),
    .burstEnd     (burstEnd),
    .overflow     (overflow),
    .busy         (busy)
  );

  always #5 inclk = ~inclk;

  // Generator model: word appears Lat cycles after its read strobe.
  always @(posedge inclk or negedge nReset) begin
    if (!nReset) rd_pipe <= '0;
    else         rd_pipe <= {rd_pipe[Lat-2:0], readData};
  end
  always @(posedge inclk) begin
    if (rd_pipe[Lat-1]) gen_word <= gen_word + 16'd1;
  end
  assign genData = gen_word;

  always @(negedge inclk) begin
    if (usbWrite && log_n < 256) begin
      log_data[log_n] = usbData;
      log_end[log_n]  = burstEnd;
      log_n           = log_n + 1;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // The FIFO must never be popped while empty.
  always @(negedge inclk) begin
    if (nReset && dut.u_fifo.pop)
      check_eq("pop_not_empty", 32'(dut.u_fifo.count != '0), 32'd1);
  end

  task automatic tick(input int n);
    repeat (n) @(negedge inclk);
  endtask

  task automatic wait_idle(input string tag, input int max);
    int i = 0;
    while (busy && i < max) begin
      @(negedge inclk);
      i++;
    end
    check_eq({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  // Words logged from index start: ndata data words from base, then zero pads up to ntotal;
  // burstEnd on every BurstLen-th word and on the last.
  task automatic check_stream(input string tag, input int start, input int ndata,
                              input int ntotal, input logic [15:0] base);
    check_eq({tag, "_len"}, 32'(log_n - start), 32'(ntotal));
    for (int i = 0; i < ntotal; i++) begin
      logic [15:0] ed;
      logic        ee;
      ed = (i < ndata) ? base + 16'(i) : 16'h0;
      ee = ((i % BurstLen) == BurstLen - 1) || (i == ntotal - 1);
      check_eq($sformatf("%s_data%0d", tag, i), 32'(log_data[start + i]), 32'(ed));
      check_eq($sformatf("%s_end%0d", tag, i), 32'(log_end[start + i]), 32'(ee));
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_ctrl"},
             32'({collectData, readData, testMode, usbWrite, burstEnd, overflow, busy}), 32'd0);
    check_eq({tag, "_data"}, 32'(usbData), 32'd0);
    check_eq({tag, "_count"}, 32'(dut.u_fifo.count), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got still running, expected finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    int          start;
    int          seen;
    int          cyc;
    logic [15:0] base;

    #1 nReset = 1'b0;
    tick(2);
    check_all_zero("reset");
    nReset = 1'b1;
    tick(2);

    // 1: continuous test-mode capture, 40 cycles of collectEnable -> 39 reads.
    start = log_n; base = gen_word;
    testModeIn = 1'b1; genAvailable = 1'b1; usbReady = 1'b1; collectEnable = 1'b1;
    tick(1);
    check_eq("t1_collect", 32'({collectData, busy, testMode}), 32'b111);
    testModeIn = 1'b0;
    tick(39);
    collectEnable = 1'b0;
    check_eq("t1_testmode_held", 32'(testMode), 32'd1);
    wait_idle("t1", 200);
    check_stream("t1", start, 39, PadEn ? 40 : 39, base);
    check_eq("t1_overflow", 32'(overflow), 32'd0);

    // 2: USB stalled while collecting, FIFO fills and refuses samples.
    start = log_n; base = gen_word;
    usbReady = 1'b0; collectEnable = 1'b1;
    tick(30);
    check_eq("t2_count", 32'(dut.u_fifo.count), 32'd16);
    check_eq("t2_no_read", 32'(readData), 32'd0);
    check_eq("t2_overflow", 32'(overflow), 32'd1);
    check_eq("t2_testmode", 32'(testMode), 32'd0);
    check_eq("t2_no_usb", 32'(log_n - start), 32'd0);
    collectEnable = 1'b0;
    tick(8);
    check_eq("t2_flush", 32'(dut.state_q), 32'(StFlush));
    usbReady = 1'b1;
    wait_idle("t2", 200);
    check_stream("t2", start, 16, 16, base);

    // 3: stop with 5 words buffered.
    start = log_n; base = gen_word;
    genAvailable = 1'b0; collectEnable = 1'b1;
    tick(1);
    check_eq("t3_overflow_clr", 32'(overflow), 32'd0);
    genAvailable = 1'b1;
    tick(5);
    genAvailable = 1'b0;
    tick(6);
    collectEnable = 1'b0;
    wait_idle("t3", 200);
    check_stream("t3", start, 5, PadEn ? 8 : 5, base);

    // 4: collectEnable drops the cycle after the last read; drain waits for 3 in flight.
    start = log_n; base = gen_word;
    collectEnable = 1'b1;
    tick(1);
    genAvailable = 1'b1;
    tick(3);
    genAvailable = 1'b0; collectEnable = 1'b0;
    tick(1);
    check_eq("t4_drain_a", 32'(dut.state_q), 32'(StDrain));
    tick(2);
    check_eq("t4_drain_b", 32'(dut.state_q), 32'(StDrain));
    check_eq("t4_count", 32'(dut.u_fifo.count), 32'd3);
    tick(1);
    check_eq("t4_flush", 32'(dut.state_q), 32'(StFlush));
    wait_idle("t4", 200);
    check_stream("t4", start, 3, PadEn ? 8 : 3, base);

    // 5: reset on the 4th word of a burst, then a clean capture.
    base = gen_word;
    testModeIn = 1'b1; genAvailable = 1'b1; collectEnable = 1'b1;
    seen = 0; cyc = 0;
    while (seen < 4 && cyc < 100) begin
      @(negedge inclk);
      cyc++;
      if (usbWrite) seen++;
    end
    check_eq("t5_reach4", 32'(seen), 32'd4);
    check_eq("t5_word4", 32'(usbData), 32'(base + 16'd3));
    nReset = 1'b0; collectEnable = 1'b0; genAvailable = 1'b0; testModeIn = 1'b0;
    #1;
    check_all_zero("t5_rst");
    check_eq("t5_rst_state", 32'(dut.state_q), 32'(StIdle));
    @(negedge inclk);
    nReset = 1'b1;
    tick(2);
    start = log_n; base = gen_word;
    collectEnable = 1'b1;
    tick(1);
    check_eq("t5_restart", 32'({busy, overflow, testMode}), 32'b100);
    genAvailable = 1'b1;
    tick(8);
    genAvailable = 1'b0;
    tick(2);
    collectEnable = 1'b0;
    wait_idle("t5", 200);
    check_stream("t5", start, 8, 8, base);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
